// File: rtl/gcd_pkg.sv
// Shared GCD datapath types: default width and multiplier states.
// The GCD controller imports this package as well.
package gcd_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/shift_add_mult_if.sv
// Start/result bundle of the shift-and-add multiplier.
// The master drives operands and start; the slave returns status and product.
interface shift_add_mult_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               ready;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );

endinterface

// File: rtl/shift_add_mult_addc.sv
// Combinational WIDTH-bit adder with carry-out.
// Port shape matches the subtractor so the two units are interchangeable.
module addc
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Full-width add; the extra bit lands in cout.
    always_comb begin
        {cout, sum} = {1'b0, in1} + {1'b0, in2};
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, fixed WIDTH-cycle run.
// P holds {partial upper, remaining multiplier bits} and is the product.
module shift_add_mult
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    shift_add_mult_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    mult_state_t        state_q;
    mult_state_t        state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] p_q;
    logic [2*WIDTH-1:0] p_next;
    logic [CW-1:0]      count_q;
    logic               load;
    logic               step;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH:0]     upper;

    addc #(
        .WIDTH (WIDTH)
    ) u_addc (
        .in1  (p_q[2*WIDTH-1:WIDTH]),
        .in2  (mcand_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Conditional add, then shift the (2W+1)-bit value right by one.
    always_comb begin
        upper = {1'b0, p_q[2*WIDTH-1:WIDTH]};
        if (p_q[0]) begin
            upper = {add_cout, add_sum};
        end
        p_next = {upper, p_q[WIDTH-1:1]};
    end

    // State register; reset aborts any run in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and load/step strobes; code 3 falls back to IDLE.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture on accept, one iteration per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            p_q     <= '0;
            count_q <= '0;
        end else if (load) begin
            mcand_q <= bus.a;
            p_q     <= {{WIDTH{1'b0}}, bus.b};
            count_q <= '0;
        end else if (step) begin
            p_q     <= p_next;
            count_q <= count_q + CW'(1);
        end
    end

    // Moore status decode from registered state only.
    always_comb begin
        bus.ready   = (state_q == IDLE) || (state_q == DONE);
        bus.busy    = (state_q == RUN);
        bus.done    = (state_q == DONE);
        bus.product = p_q;
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and random bench for the shift-and-add multiplier.
// Each task drives one scenario and checks its own results.
module tb_shift_add_mult;

    localparam int W = 16;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    shift_add_mult_if #(.WIDTH(W)) bus ();

    shift_add_mult #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [2*W-1:0] prod, output int edges);
        int w;
        w = 0;
        while (!bus.ready && w < 40) begin
            tick();
            w++;
        end
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        edges = 0;
        while (!bus.done && edges < 40) begin
            tick();
            edges++;
        end
        prod = bus.product;
    endtask

    task automatic test_reset();
        total++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL reset_flags got r%b b%b d%b want r1 b0 d0",
                     bus.ready, bus.busy, bus.done);
        end else passed++;
        total++;
        if (bus.product !== 32'h0) begin
            $display("FAIL reset_product got %h want 00000000", bus.product);
        end else passed++;
    endtask

    task automatic test_basic();
        int busy_cnt;
        int n;
        bus.a = 16'd3;
        bus.b = 16'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL basic_accept got r%b b%b want r0 b1",
                     bus.ready, bus.busy);
        end else passed++;
        busy_cnt = 0;
        n = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            n++;
        end
        total++;
        if (busy_cnt != 16 || n != 16) begin
            $display("FAIL basic_latency busy %0d edges %0d want 16 16",
                     busy_cnt, n);
        end else passed++;
        total++;
        if (bus.done !== 1'b1 || bus.product !== 32'h0000000F) begin
            $display("FAIL basic_product done %b got %h want 0000000f",
                     bus.done, bus.product);
        end else passed++;
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1 ||
            bus.product !== 32'h0000000F) begin
            $display("FAIL basic_hold d%b r%b got %h want d0 r1 0000000f",
                     bus.done, bus.ready, bus.product);
        end else passed++;
        tick();
        total++;
        if (bus.product !== 32'h0000000F || bus.busy !== 1'b0) begin
            $display("FAIL basic_idle_hold got %h busy %b", bus.product,
                     bus.busy);
        end else passed++;
    endtask

    task automatic test_corners();
        logic [2*W-1:0] p;
        int e;
        run_op(16'hFFFF, 16'hFFFF, p, e);
        total++;
        if (p !== 32'hFFFE0001 || e != 16) begin
            $display("FAIL max_product got %h edges %0d want fffe0001 16",
                     p, e);
        end else passed++;
        run_op(16'h0000, 16'h1234, p, e);
        total++;
        if (p !== 32'h0 || e != 16) begin
            $display("FAIL zero_product got %h edges %0d want 0 16", p, e);
        end else passed++;
        run_op(16'h1234, 16'h0001, p, e);
        total++;
        if (p !== 32'h00001234 || e != 16) begin
            $display("FAIL one_product got %h edges %0d want 1234 16", p, e);
        end else passed++;
        run_op(16'h8000, 16'h8000, p, e);
        total++;
        if (p !== 32'h40000000 || e != 16) begin
            $display("FAIL msb_product got %h edges %0d want 40000000 16",
                     p, e);
        end else passed++;
        tick();
    endtask

    task automatic test_ignore();
        int n;
        int extra;
        bus.a = 16'd7;
        bus.b = 16'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        repeat (4) begin
            tick();
            n++;
        end
        bus.a = 16'd2;
        bus.b = 16'd2;
        bus.start = 1'b1;
        tick();
        n++;
        bus.start = 1'b0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (bus.product !== 32'd63 || n != 16) begin
            $display("FAIL ignore_product got %0d edges %0d want 63 16",
                     bus.product, n);
        end else passed++;
        extra = 0;
        repeat (20) begin
            tick();
            if (bus.done) extra++;
        end
        total++;
        if (extra != 0) begin
            $display("FAIL ignore_extra_done got %0d want 0", extra);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] p;
        int e;
        run_op(16'd5, 16'd6, p, e);
        total++;
        if (p !== 32'd30 || bus.done !== 1'b1) begin
            $display("FAIL b2b_first got %0d done %b want 30 1", p, bus.done);
        end else passed++;
        bus.a = 16'h0100;
        bus.b = 16'h0100;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            $display("FAIL b2b_restart busy got %b want 1", bus.busy);
        end else passed++;
        e = 0;
        while (!bus.done && e < 40) begin
            tick();
            e++;
        end
        total++;
        if (bus.product !== 32'h00010000 || e != 16) begin
            $display("FAIL b2b_second got %h edges %0d want 00010000 16",
                     bus.product, e);
        end else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        logic [2*W-1:0] p;
        int e;
        int extra;
        bus.a = 16'hABCD;
        bus.b = 16'hFFFF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.product !== 32'h0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            $display("FAIL async_reset got p%h b%b d%b r%b want 0 0 0 1",
                     bus.product, bus.busy, bus.done, bus.ready);
        end else passed++;
        tick();
        rst = 1'b0;
        extra = 0;
        repeat (20) begin
            tick();
            if (bus.done || bus.busy) extra++;
        end
        total++;
        if (extra != 0) begin
            $display("FAIL reset_no_done got %0d active cycles want 0",
                     extra);
        end else passed++;
        run_op(16'd12, 16'd11, p, e);
        total++;
        if (p !== 32'd132 || e != 16) begin
            $display("FAIL post_reset got %0d edges %0d want 132 16", p, e);
        end else passed++;
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] want;
        logic [2*W-1:0] p;
        int e;
        int starts;
        int dones;
        starts = 0;
        dones = 0;
        for (int i = 0; i < 1000; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            want = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            run_op(x, y, p, e);
            starts++;
            if (bus.done) dones++;
            total++;
            if (p !== want) begin
                $display("FAIL rand_%0d %h*%h got %h want %h",
                         i, x, y, p, want);
            end else passed++;
            repeat ($urandom_range(0, 3)) tick();
        end
        total++;
        if (dones != starts) begin
            $display("FAIL rand_done_count got %0d want %0d", dones, starts);
        end else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_corners();
        test_ignore();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
- Sequential unsigned shift-and-add multiplier for the GCD datapath.
- It is the addition-side counterpart of the combinational subtractor: repeated conditional add plus shift, where the subtractor does repeated subtract.
- Used to reconstruct operands from a GCD result, e.g. g*k == a, and as the multiply step for LCM.
- Computes one WIDTH x WIDTH -> 2*WIDTH product per start request, at a fixed latency.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when ready.
- a  input  WIDTH  multiplicand; captured when start is accepted.
- b  input  WIDTH  multiplier; captured when start is accepted.
- ready  output  1  high in IDLE and DONE; start is accepted only when ready=1.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; product is valid from that cycle onward.
- product  output  2*WIDTH  result; held until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, product=0, done=0, busy=0, ready=1, internal count=0.
  - Reset asserted mid-operation aborts immediately; no done pulse is produced for the aborted request.
- Internal registers:
  - mcand[WIDTH].
  - P[2*WIDTH], which is also the product register.
  - count[$clog2(WIDTH+1)].
- State IDLE:
  - start=1 at a rising edge: mcand<=a, P<={WIDTH zeros, b}, count<=0, go to RUN.
- State RUN, each clock:
  - If P[0]=1: upper = {carry, P[2W-1:W]} = P[2W-1:W] + mcand, computed at WIDTH+1 bits. Otherwise upper = {0, P[2W-1:W]}.
  - P <= {upper, P[W-1:1]}. This is a logical right shift of the (2W+1)-bit value; the carry is never lost.
  - count <= count+1.
  - When count==WIDTH-1 (last iteration), go to DONE.
- RUN lasts exactly WIDTH cycles.
- State DONE:
  - done=1 for exactly this one cycle; product = P = a*b.
  - Next edge: start=1 reloads and goes to RUN (back-to-back allowed); otherwise go to IDLE.
- Latency:
  - Start accepted at edge k; done is high in the cycle after edge k+WIDTH.
  - That is WIDTH+1 cycles from acceptance to done; throughput is one result per WIDTH+1 cycles.
- Outputs:
  - ready, busy and done are decoded from registered state only (Moore); there is no combinational path from start.
- start while busy=1: ignored entirely. There is no queuing, and a and b are not re-sampled.
- a and b may change freely after acceptance.
- product during RUN:
  - Shows intermediate P. Consumers sample only at done or later.
  - After done, product is stable through IDLE until the next accepted start.
- Arithmetic: unsigned only.
  - Max case (2^W-1)^2 fits in 2W bits, so there is no overflow.
  - Zero operands still take the full WIDTH cycles. There is no early termination.
- State encoding is 2 bits: IDLE=0, RUN=1, DONE=2. Code 3 is illegal and recovers to IDLE on the next edge.

Decomposition:
- Package gcd_pkg:
  - localparam DEF_WIDTH=16.
  - typedef enum logic[1:0] mult_state_t {IDLE, RUN, DONE}.
  - Shared with the GCD controller.
- One sub-module, addc:
  - Combinational WIDTH-bit adder with carry-out.
  - Ports in1, in2, sum[WIDTH], cout.
  - Mirrors the existing subtractor's style so add and subtract units are interchangeable in the datapath.
- Everything else is inline: FSM, counter, P register.

Test Plan:
- Reset, then a=3, b=5, start one cycle:
  - ready drops; busy=1 for exactly 16 cycles.
  - done pulses in the 17th cycle after acceptance with product=0x0000000F.
  - product holds 0x0000000F afterwards and ready=1.
- a=0xFFFF, b=0xFFFF -> product=0xFFFE0001 at done (carry path exercised). Also a=0, b=0x1234 -> product=0 after the full 17-cycle latency.
- a=7, b=9 started; start pulsed again with a=2, b=2 during cycle 5 of RUN:
  - The second start is ignored; a single done with product=63.
  - No second done within the following 20 cycles.
- Back-to-back: start held high in the DONE cycle with a=0x0100, b=0x0100:
  - The first result is seen at done.
  - The second run starts immediately; its done comes 17 cycles later with product=0x00010000.
- rst asserted asynchronously (mid-cycle) at RUN cycle 8:
  - Outputs go to product=0, busy=0, done=0, ready=1 without waiting for a clock edge.
  - No done pulse follows.
  - A fresh start with a=12, b=11 then yields 132.
- Random regression: 1000 random a/b pairs, each with random idle gaps. Product is checked against the reference a*b at every done pulse, and the done count equals the accepted-start count.
